// File: rtl/spi_slave.sv
// SPI mode-0 responder with 8-bit frames, oversampled in the system clock domain.
// CPU side: one-byte TX buffer and an RX holding register with new/overrun flags.
module spi_slave #(
   parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_clk,
   input  logic       mosi,
   input  logic       spi_cs,
   output logic       miso,
   input  logic [7:0] tx_data,
   input  logic       tx_write,
   output logic [7:0] rx_data,
   input  logic       rx_read,
   output logic       rx_new,
   output logic       tx_ready,
   output logic       overrun,
   output logic       busy
);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   state_t      state, state_nxt;
   logic [2:0]  sck_sync, cs_sync;
   logic [1:0]  mosi_sync;
   logic        post_rst, armed;
   logic [2:0]  bit_cnt;
   logic [6:0]  tx_shift, rx_shift;
   logic [7:0]  tx_buf, load_byte;
   logic        sck_rise, sck_fall, cs_rise, cs_fall;
   logic        do_start, do_load, do_shift, do_rx, do_abort, rx_done;

   assign sck_rise  = sck_sync[1] & ~sck_sync[2];
   assign sck_fall  = ~sck_sync[1] & sck_sync[2];
   assign cs_rise   = cs_sync[1] & ~cs_sync[2];
   assign cs_fall   = ~cs_sync[1] & cs_sync[2];
   assign load_byte = tx_ready ? IDLE_BYTE : tx_buf;
   assign rx_done   = do_rx && (bit_cnt == 3'd7);
   assign busy      = (state == S_ACTIVE);

   always_ff @(posedge clk) begin
      if (rst) begin
         sck_sync  <= 3'b000;
         cs_sync   <= 3'b111;
         mosi_sync <= 2'b00;
         post_rst  <= 1'b0;
         armed     <= 1'b0;
         state     <= S_IDLE;
      end else begin
         sck_sync  <= {sck_sync[1:0], spi_clk};
         cs_sync   <= {cs_sync[1:0], spi_cs};
         mosi_sync <= {mosi_sync[0], mosi};
         post_rst  <= 1'b1;
         // A start needs cs seen high after reset, so a frame cut by reset is not resumed.
         armed     <= armed | (post_rst & cs_sync[0]);
         state     <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      do_start  = 1'b0;
      do_load   = 1'b0;
      do_shift  = 1'b0;
      do_rx     = 1'b0;
      do_abort  = 1'b0;
      case (state)
         S_IDLE: begin
            if (cs_fall && armed) begin
               state_nxt = S_ACTIVE;
               do_start  = 1'b1;
               do_load   = 1'b1;
            end
         end
         S_ACTIVE: begin
            if (cs_rise) begin
               state_nxt = S_IDLE;
               do_abort  = 1'b1;
            end else begin
               do_rx = sck_rise;
               if (sck_fall) begin
                  if (bit_cnt == 3'd0) do_load  = 1'b1;
                  else                 do_shift = 1'b1;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         miso     <= 1'b1;
         tx_shift <= 7'd0;
         rx_shift <= 7'd0;
         bit_cnt  <= 3'd0;
         tx_buf   <= 8'd0;
         tx_ready <= 1'b1;
         rx_data  <= 8'd0;
         rx_new   <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (do_load) begin
            tx_shift <= load_byte[6:0];
            miso     <= load_byte[7];
            tx_ready <= 1'b1;
         end else if (do_shift) begin
            tx_shift <= {tx_shift[5:0], 1'b0};
            miso     <= tx_shift[6];
         end else if (do_abort) begin
            miso <= 1'b1;
         end
         // A write in the same cycle as a load stays pending for the next byte.
         if (tx_write) begin
            tx_buf   <= tx_data;
            tx_ready <= 1'b0;
         end
         if (do_start || do_abort) bit_cnt <= 3'd0;
         else if (do_rx)           bit_cnt <= bit_cnt + 3'd1;
         if (do_rx) rx_shift <= {rx_shift[5:0], mosi_sync[1]};
         if (rx_read) begin
            rx_new  <= 1'b0;
            overrun <= 1'b0;
         end
         if (rx_done) begin
            rx_data <= {rx_shift, mosi_sync[1]};
            rx_new  <= 1'b1;
            if (rx_new && !rx_read) overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master model with 5-clk half periods.
`timescale 1ns/1ps
module tb_spi_slave;
   localparam int H = 5;

   logic       clk, rst, spi_clk, mosi, spi_cs, miso;
   logic [7:0] tx_data, rx_data;
   logic       tx_write, rx_read, rx_new, tx_ready, overrun, busy;
   int         tests = 0, fails = 0;
   logic [7:0] mi, m0, m1, m2;
   logic       nw2, nw3, ov3;

   spi_slave #(.IDLE_BYTE(8'hFF)) dut (
      .clk(clk), .rst(rst), .spi_clk(spi_clk), .mosi(mosi), .spi_cs(spi_cs),
      .miso(miso), .tx_data(tx_data), .tx_write(tx_write), .rx_data(rx_data),
      .rx_read(rx_read), .rx_new(rx_new), .tx_ready(tx_ready),
      .overrun(overrun), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic cpu_write(input logic [7:0] d);
      tx_data = d; tx_write = 1'b1; tick(); tx_write = 1'b0;
   endtask

   task automatic cpu_read();
      rx_read = 1'b1; tick(); rx_read = 1'b0;
   endtask

   task automatic cs_down();
      spi_cs = 1'b0; repeat (H) tick();
   endtask

   task automatic cs_up();
      repeat (H) tick(); spi_cs = 1'b1; repeat (H) tick();
   endtask

   // Sends the top n bits of mo; on the 8th rise records rx_new 2 and 3 clk later,
   // optionally pulsing rx_read on the completion cycle.
   task automatic spi_bits(input logic [7:0] mo, input int n, input bit rd, output logic [7:0] got);
      got = 8'h00;
      for (int k = 0; k < n; k++) begin
         mosi = mo[7-k];
         repeat (H) tick();
         got[7-k] = miso;
         spi_clk = 1'b1;
         if (k == 7) begin
            tick(); tick();
            nw2 = rx_new;
            if (rd) rx_read = 1'b1;
            tick();
            nw3 = rx_new; ov3 = overrun; rx_read = 1'b0;
            repeat (H-3) tick();
         end else begin
            repeat (H) tick();
         end
         spi_clk = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; repeat (3) tick(); rst = 1'b0; repeat (4) tick();
      tests++; if (miso !== 1'b1)     begin fails++; $display("FAIL reset_miso: got %b exp 1", miso); end
      tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready: got %b exp 1", tx_ready); end
      tests++; if (rx_new !== 1'b0)   begin fails++; $display("FAIL reset_rx_new: got %b exp 0", rx_new); end
      tests++; if (overrun !== 1'b0)  begin fails++; $display("FAIL reset_overrun: got %b exp 0", overrun); end
      tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy: got %b exp 0", busy); end
      tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h exp 00", rx_data); end
   endtask

   task automatic test_single();
      cpu_write(8'hA5);
      tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL single_tx_pending: got %b exp 0", tx_ready); end
      cs_down();
      tests++; if (busy !== 1'b1)     begin fails++; $display("FAIL single_busy: got %b exp 1", busy); end
      tests++; if (tx_ready !== 1'b1) begin fails++; $display("FAIL single_tx_consumed: got %b exp 1", tx_ready); end
      spi_bits(8'h3C, 8, 1'b0, mi);
      tests++; if (mi !== 8'hA5)      begin fails++; $display("FAIL single_miso_byte: got %h exp a5", mi); end
      tests++; if (nw2 !== 1'b0)      begin fails++; $display("FAIL single_rx_new_early: got %b exp 0", nw2); end
      tests++; if (nw3 !== 1'b1)      begin fails++; $display("FAIL single_rx_new_3clk: got %b exp 1", nw3); end
      tests++; if (rx_data !== 8'h3C) begin fails++; $display("FAIL single_rx_data: got %h exp 3c", rx_data); end
      cs_up();
      tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL single_busy_end: got %b exp 0", busy); end
      tests++; if (miso !== 1'b1)     begin fails++; $display("FAIL single_miso_idle: got %b exp 1", miso); end
   endtask

   task automatic test_back_to_back();
      cpu_read();
      cpu_write(8'h11);
      cs_down();
      spi_bits(8'hC1, 8, 1'b0, m0);
      tests++; if (rx_data !== 8'hC1) begin fails++; $display("FAIL b2b_rx0: got %h exp c1", rx_data); end
      tests++; if (ov3 !== 1'b0)      begin fails++; $display("FAIL b2b_ovr0: got %b exp 0", ov3); end
      spi_bits(8'hC2, 8, 1'b0, m1);
      tests++; if (rx_data !== 8'hC2) begin fails++; $display("FAIL b2b_rx1: got %h exp c2", rx_data); end
      tests++; if (ov3 !== 1'b1)      begin fails++; $display("FAIL b2b_ovr1: got %b exp 1", ov3); end
      spi_bits(8'hC3, 8, 1'b0, m2);
      tests++; if (rx_data !== 8'hC3) begin fails++; $display("FAIL b2b_rx2: got %h exp c3", rx_data); end
      cs_up();
      tests++; if (m0 !== 8'h11)      begin fails++; $display("FAIL b2b_miso0: got %h exp 11", m0); end
      tests++; if (m1 !== 8'hFF)      begin fails++; $display("FAIL b2b_miso1: got %h exp ff", m1); end
      tests++; if (m2 !== 8'hFF)      begin fails++; $display("FAIL b2b_miso2: got %h exp ff", m2); end
      cpu_read();
      tests++; if (rx_new !== 1'b0)   begin fails++; $display("FAIL b2b_read_new: got %b exp 0", rx_new); end
      tests++; if (overrun !== 1'b0)  begin fails++; $display("FAIL b2b_read_ovr: got %b exp 0", overrun); end
   endtask

   task automatic test_read_collision();
      cs_down();
      spi_bits(8'h5A, 8, 1'b0, mi);
      spi_bits(8'h96, 8, 1'b1, mi);
      tests++; if (nw2 !== 1'b1)      begin fails++; $display("FAIL coll_pre_new: got %b exp 1", nw2); end
      tests++; if (nw3 !== 1'b1)      begin fails++; $display("FAIL coll_rx_new: got %b exp 1", nw3); end
      tests++; if (ov3 !== 1'b0)      begin fails++; $display("FAIL coll_overrun: got %b exp 0", ov3); end
      tests++; if (rx_data !== 8'h96) begin fails++; $display("FAIL coll_rx_data: got %h exp 96", rx_data); end
      cs_up();
   endtask

   task automatic test_cs_abort();
      cpu_read();
      cs_down();
      spi_bits(8'hF0, 5, 1'b0, mi);
      cs_up();
      tests++; if (rx_data !== 8'h96) begin fails++; $display("FAIL abort_rx_data: got %h exp 96", rx_data); end
      tests++; if (rx_new !== 1'b0)   begin fails++; $display("FAIL abort_rx_new: got %b exp 0", rx_new); end
      tests++; if (miso !== 1'b1)     begin fails++; $display("FAIL abort_miso: got %b exp 1", miso); end
      cpu_write(8'h3A);
      cs_down();
      spi_bits(8'h81, 8, 1'b0, mi);
      cs_up();
      tests++; if (rx_data !== 8'h81) begin fails++; $display("FAIL abort_next_rx: got %h exp 81", rx_data); end
      tests++; if (nw3 !== 1'b1)      begin fails++; $display("FAIL abort_next_new: got %b exp 1", nw3); end
      tests++; if (mi !== 8'h3A)      begin fails++; $display("FAIL abort_next_miso: got %h exp 3a", mi); end
   endtask

   task automatic test_reset_mid_frame();
      cs_down();
      spi_bits(8'hAA, 3, 1'b0, mi);
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      cpu_write(8'h00);
      spi_bits(8'h42, 8, 1'b0, mi);
      tests++; if (rx_new !== 1'b0)   begin fails++; $display("FAIL rstmid_rx_new: got %b exp 0", rx_new); end
      tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL rstmid_rx_data: got %h exp 00", rx_data); end
      tests++; if (mi !== 8'hFF)      begin fails++; $display("FAIL rstmid_miso: got %h exp ff", mi); end
      tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL rstmid_busy: got %b exp 0", busy); end
      tests++; if (tx_ready !== 1'b0) begin fails++; $display("FAIL rstmid_tx_kept: got %b exp 0", tx_ready); end
      cs_up();
      cs_down();
      spi_bits(8'h24, 8, 1'b0, mi);
      cs_up();
      tests++; if (mi !== 8'h00)      begin fails++; $display("FAIL rstmid_next_miso: got %h exp 00", mi); end
      tests++; if (rx_data !== 8'h24) begin fails++; $display("FAIL rstmid_next_rx: got %h exp 24", rx_data); end
      tests++; if (rx_new !== 1'b1)   begin fails++; $display("FAIL rstmid_next_new: got %b exp 1", rx_new); end
   endtask

   initial begin
      rst = 1'b1; spi_clk = 1'b0; mosi = 1'b0; spi_cs = 1'b1;
      tx_data = 8'h00; tx_write = 1'b0; rx_read = 1'b0;
      nw2 = 1'b0; nw3 = 1'b0; ov3 = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_read_collision();
      test_cs_abort();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
